ledpwm: RTL
===========

# ledpwm

Per-LED PWM brightness and fade engine for the 9 badge LEDs. It takes CPU register writes, runs a shared 8-bit PWM counter, and drives the 9-bit on/off vector consumed by the LED multiplex driver (`ledctl`). When fading is enabled, each channel moves one step per fade tick toward its programmed target.

## Interface
- `PWM_DIV`, default 4: clk cycles per PWM counter step. Legal range is 1 or more. PWM period = 256*PWM_DIV cycles.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `addr` in 4: register word address.
- `din` in 32: write data.
- `wen` in 1: write strobe, one cycle per access.
- `ren` in 1: read strobe, one cycle per access.
- `dout` out 32: read data, valid while `ready`=1.
- `ready` out 1: access acknowledge.
- `led` out 9: per-LED on/off vector to the multiplex driver.

## Operation
Register map:
- 0..8: channel n.
  - Write: `target[n]` <= `din[7:0]`.
  - Read: {16'h0, target[n], level[n]}.
- 9: CTRL.
  - Bit 0: `fade_en`.
  - Bits [15:8]: `fade_rate`.
  - Read: {16'h0, fade_rate, 7'h0, fade_en}.
- 10: STATUS, read-only. Bit n = (level[n] != target[n]); bits [31:9] = 0.
- 11..15: reads return 0; writes are ignored.

Bus handshake:
- `ready` is registered. It is 1 exactly one cycle after any cycle with `wen` or `ren`, otherwise 0.
- `dout` is 0 whenever `ready`=0.
- Read data is sampled in the strobe cycle.
- `wen` and `ren` together: the write is performed, and `dout` returns the pre-write value.
- Back-to-back strobes on consecutive cycles are legal. Each one gets its own `ready`.

PWM:
- Prescaler counts 0..PWM_DIV-1. `pwm_ctr` (8 bits) increments on prescaler wrap and wraps 255->0.
- `led[n]` <= (level[n] > pwm_ctr), registered.
  - Level 0 is always off.
  - Level 255 is on 255 of 256 steps.

Fade:
- `period_tick` is asserted for one cycle when `pwm_ctr` wraps 255->0.
- An 8-bit `fade_cnt` increments on each `period_tick`. When `fade_cnt` == `fade_rate`, it clears and issues `fade_tick`. A `fade_tick` therefore occurs every (fade_rate+1) PWM periods.
- On `fade_tick` with `fade_en`=1, every channel with level != target moves by 1 toward target, with no overshoot.
- With `fade_en`=0, level[n] <= target[n] every cycle. A write therefore lands in `level` on the next cycle.
- Clearing `fade_en` mid-fade snaps all levels to their targets on the next cycle.
- `fade_cnt` is not reset on CTRL writes.

Simultaneous events:
- A channel write coincident with `fade_tick`: the write updates `target`; the fade step for that channel uses the old target that cycle.
- A CTRL write coincident with `fade_tick`: the fade step uses the old `fade_en`.

## Timing
- Reset values:
  - `led`=0, `dout`=0, `ready`=0.
  - All level/target = 0; `fade_en`=0; `fade_rate`=0.
  - Prescaler, `pwm_ctr` and `fade_cnt` = 0.
- Reset mid-access drops the pending `ready`. Reset mid-fade zeroes levels immediately.
- Write to `led` latency, with `fade_en`=0:
  - Cycle 0: `wen`.
  - Cycle 1: `level` updated.
  - Cycle 2: `led` reflects the new comparison.
- Read latency: 1 cycle (strobe in cycle 0; `ready` and `dout` valid in cycle 1).
- Full fade from 0 to 255 with `fade_rate`=r: 255*(r+1) PWM periods.

## Test plan
- Reset behaviour: assert `rst` mid-fade.
  - Next cycle: `led`=0, `ready`=0.
  - Reading channel 0 returns 0; CTRL returns 0.
- Static PWM with PWM_DIV=4, `fade_en`=0.
  - Write ch0=128, ch8=255, ch4=0.
  - Over one 1024-cycle period: `led[0]` high 512 cycles, `led[8]` high 1020 cycles, `led[4]` never high.
- Bus handshake.
  - Write addr 3 = 32'h12345677; read addr 3 next cycle.
  - `ready` = 1 on each following cycle; `dout` = 32'h00007777.
  - Read addr 12 returns 0 with `ready`=1.
- Fade.
  - CTRL = 32'h0000_0101 (`fade_en`=1, rate 1); write ch2=3.
  - `level[2]` reaches 1, 2, 3 on successive fade ticks, 2 PWM periods apart.
  - STATUS bit 2 clears once level = 3.
  - A subsequent write of 0 decrements `level[2]` back to 0.
- Fade abort: mid-fade toward 200 at level 50, write CTRL = 0.
  - Next cycle level = 200; STATUS = 0.
- Simultaneous events:
  - `wen`+`ren` on addr 1 (old target 5, new 9): `dout` shows target 5; a later read shows 9.
  - A write coincident with `fade_tick` follows the rule in Operation.

Source files
------------

// File: rtl/ledpwm_if.sv
// ledpwm_if: CPU register bus used by the LED PWM engine.
//   addr  : register word address (master -> slave)
//   din   : write data (master -> slave)
//   wen   : write strobe, one cycle per access (master -> slave)
//   ren   : read strobe, one cycle per access (master -> slave)
//   dout  : read data, valid while ready=1, else 0 (slave -> master)
//   ready : access acknowledge, one cycle after each strobe (slave -> master)
interface ledpwm_if;
    logic [3:0]  addr;
    logic [31:0] din;
    logic        wen;
    logic        ren;
    logic [31:0] dout;
    logic        ready;

    modport master (output addr, din, wen, ren, input dout, ready);
    modport slave  (input addr, din, wen, ren, output dout, ready);
endinterface

// File: rtl/ledpwm.sv
// ledpwm: per-LED PWM brightness and fade engine for the 9 badge LEDs.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset
//   bus    : register bus (slave side), see ledpwm_if
//   led_o  : registered per-LED on/off vector to the LED multiplex driver
// Register map: 0..8 channel target (read {target, level}), 9 CTRL
// ({fade_rate, fade_en}), 10 STATUS (level != target), 11..15 read as 0.
module ledpwm #(
    parameter int PWM_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ledpwm_if.slave    bus,
    output logic [8:0] led_o
);
    localparam int                PSC_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(PWM_DIV - 1);

    logic [PSC_W-1:0] psc_q, psc_d;
    logic [7:0]       pwm_ctr_q, pwm_ctr_d;
    logic [7:0]       fade_cnt_q, fade_cnt_d;
    logic [7:0]       fade_rate_q, fade_rate_d;
    logic             fade_en_q, fade_en_d;
    logic [7:0]       target_q [9];
    logic [7:0]       target_d [9];
    logic [7:0]       level_q [9];
    logic [7:0]       level_d [9];
    logic [8:0]       led_q, led_d;
    logic             ready_q, ready_d;
    logic [31:0]      dout_q, dout_d;

    logic             psc_wrap, period_tick, fade_tick, ctrl_wr;
    logic [8:0]       status;
    logic [31:0]      rdata;

    always_comb begin
        psc_wrap    = (psc_q == PSC_LAST);
        psc_d       = psc_wrap ? '0 : psc_q + 1'b1;
        pwm_ctr_d   = psc_wrap ? pwm_ctr_q + 8'd1 : pwm_ctr_q;
        period_tick = psc_wrap && (pwm_ctr_q == 8'hFF);
        fade_tick   = period_tick && (fade_cnt_q == fade_rate_q);

        fade_cnt_d = fade_cnt_q;
        if (fade_tick)
            fade_cnt_d = 8'd0;
        else if (period_tick)
            fade_cnt_d = fade_cnt_q + 8'd1;

        ctrl_wr     = bus.wen && (bus.addr == 4'd9);
        fade_en_d   = ctrl_wr ? bus.din[0]    : fade_en_q;
        fade_rate_d = ctrl_wr ? bus.din[15:8] : fade_rate_q;

        for (int n = 0; n < 9; n++) begin
            status[n]   = (level_q[n] != target_q[n]);
            target_d[n] = (bus.wen && (bus.addr == 4'(n))) ? bus.din[7:0] : target_q[n];
            led_d[n]    = (level_q[n] > pwm_ctr_q);

            // The fade step sees the pre-write fade_en and target; otherwise a
            // disabled fader tracks the (possibly just written) target so a write
            // or a fade_en clear lands in level on the very next cycle.
            level_d[n] = level_q[n];
            if (fade_en_q && fade_tick) begin
                if (level_q[n] < target_q[n])
                    level_d[n] = level_q[n] + 8'd1;
                else if (level_q[n] > target_q[n])
                    level_d[n] = level_q[n] - 8'd1;
            end else if (!fade_en_d) begin
                level_d[n] = target_d[n];
            end
        end

        rdata = 32'h0;
        for (int n = 0; n < 9; n++) begin
            if (bus.addr == 4'(n))
                rdata = {16'h0, target_q[n], level_q[n]};
        end
        if (bus.addr == 4'd9)
            rdata = {16'h0, fade_rate_q, 7'h0, fade_en_q};
        else if (bus.addr == 4'd10)
            rdata = {23'h0, status};

        ready_d = bus.wen || bus.ren;
        dout_d  = bus.ren ? rdata : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psc_q       <= '0;
            pwm_ctr_q   <= 8'd0;
            fade_cnt_q  <= 8'd0;
            fade_rate_q <= 8'd0;
            fade_en_q   <= 1'b0;
            led_q       <= 9'd0;
            ready_q     <= 1'b0;
            dout_q      <= 32'h0;
            for (int n = 0; n < 9; n++) begin
                target_q[n] <= 8'd0;
                level_q[n]  <= 8'd0;
            end
        end else begin
            psc_q       <= psc_d;
            pwm_ctr_q   <= pwm_ctr_d;
            fade_cnt_q  <= fade_cnt_d;
            fade_rate_q <= fade_rate_d;
            fade_en_q   <= fade_en_d;
            led_q       <= led_d;
            ready_q     <= ready_d;
            dout_q      <= dout_d;
            for (int n = 0; n < 9; n++) begin
                target_q[n] <= target_d[n];
                level_q[n]  <= level_d[n];
            end
        end
    end

    assign led_o     = led_q;
    assign bus.ready = ready_q;
    assign bus.dout  = dout_q;
endmodule
